// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU family: the ALU itself, the
// operand/opcode driver and the result checker all import this package.
//   WIDTH_DEF : default operand/result width
//   OP_*      : 3-bit opcode encodings
package alu_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_NOTB = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference model of the ALU, arithmetic modulo 2^WIDTH.
// Ports:
//   a, b     : operands
//   op       : opcode (alu_pkg::OP_*)
//   expected : result the ALU should produce for (a, b, op)
module alu_golden_model
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    expected = '0;
    case (op)
      OP_ADD:  expected = a + b;
      OP_SUB:  expected = a - b;
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_NOTA: expected = ~a;
      OP_NOTB: expected = ~b;
      default: expected = '0;   // OP_ZERO and the reserved opcode
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Monitor on the observed side of the ALU interface. Each qualified sample
// (a, b, op, alu_out) is paired with the golden-model result, compared one
// cycle later, and reported as a one-cycle chk_valid/chk_pass pulse two
// cycles after presentation. Keeps saturating pass/fail/skip counters and
// captures the operands/results of the first mismatch.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   clear             : synchronous clear of stats, capture and pipeline
//   in_valid          : sample qualifier
//   in_a, in_b, in_op : presented operation
//   in_result         : observed alu_out
//   chk_valid/chk_pass: result report (pass meaningful only when valid)
//   pass_cnt, fail_cnt, skip_cnt : saturating statistics
//   err               : sticky first-mismatch flag
//   ff_*              : first-mismatch capture
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int CNT_W          = 16,
  parameter bit CHECK_RESERVED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_result,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             err,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [2:0]       ff_op,
  output logic [WIDTH-1:0] ff_result,
  output logic [WIDTH-1:0] ff_expected
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [WIDTH-1:0] expected_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [2:0]       op_p1;
  logic [WIDTH-1:0] result_p1;
  logic [WIDTH-1:0] expected_p1;

  logic skip_p1;
  logic match_p1;

  alu_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a        (in_a),
    .b        (in_b),
    .op       (in_op),
    .expected (expected_p0)
  );

  // ---- stage 1: capture sample and golden result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      a_p1        <= '0;
      b_p1        <= '0;
      op_p1       <= '0;
      result_p1   <= '0;
      expected_p1 <= '0;
    end else if (clear) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        a_p1        <= in_a;
        b_p1        <= in_b;
        op_p1       <= in_op;
        result_p1   <= in_result;
        expected_p1 <= expected_p0;
      end
    end
  end

  assign skip_p1  = (op_p1 == OP_RSVD) && !CHECK_RESERVED;
  assign match_p1 = (result_p1 == expected_p1);

  // ---- stage 2: compare, report, count, capture first mismatch ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_valid   <= 1'b0;
      chk_pass    <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      skip_cnt    <= '0;
      err         <= 1'b0;
      ff_a        <= '0;
      ff_b        <= '0;
      ff_op       <= '0;
      ff_result   <= '0;
      ff_expected <= '0;
    end else if (clear) begin
      chk_valid   <= 1'b0;
      chk_pass    <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      skip_cnt    <= '0;
      err         <= 1'b0;
      ff_a        <= '0;
      ff_b        <= '0;
      ff_op       <= '0;
      ff_result   <= '0;
      ff_expected <= '0;
    end else begin
      chk_valid <= vld_p1 && !skip_p1;
      chk_pass  <= vld_p1 && !skip_p1 && match_p1;
      if (vld_p1) begin
        if (skip_p1) begin
          skip_cnt <= sat_inc(skip_cnt);
        end else if (match_p1) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          fail_cnt <= sat_inc(fail_cnt);
          // Only the first mismatch since reset/clear is captured.
          if (!err) begin
            err         <= 1'b1;
            ff_a        <= a_p1;
            ff_b        <= b_p1;
            ff_op       <= op_p1;
            ff_result   <= result_p1;
            ff_expected <= expected_p1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker. Two instances share one stimulus stream:
//   dut0 : CNT_W=4,  CHECK_RESERVED=0 (reserved op skipped, small counters)
//   dut1 : CNT_W=16, CHECK_RESERVED=1 (reserved op checked against 0)
// Expected pulses are queued when a sample is driven and popped when the
// DUT reports; statistics are tracked by a small reference model.
module tb_alu_result_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_a, in_b, in_result;
  logic [2:0] in_op;

  logic        chk_valid0, chk_pass0, err0;
  logic [3:0]  pass_cnt0, fail_cnt0, skip_cnt0;
  logic [3:0]  ff_a0, ff_b0, ff_result0, ff_expected0;
  logic [2:0]  ff_op0;

  logic        chk_valid1, chk_pass1, err1;
  logic [15:0] pass_cnt1, fail_cnt1, skip_cnt1;
  logic [3:0]  ff_a1, ff_b1, ff_result1, ff_expected1;
  logic [2:0]  ff_op1;

  always #5 clk = ~clk;

  alu_result_checker #(.WIDTH(4), .CNT_W(4), .CHECK_RESERVED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_result(in_result),
    .chk_valid(chk_valid0), .chk_pass(chk_pass0),
    .pass_cnt(pass_cnt0), .fail_cnt(fail_cnt0), .skip_cnt(skip_cnt0),
    .err(err0), .ff_a(ff_a0), .ff_b(ff_b0), .ff_op(ff_op0),
    .ff_result(ff_result0), .ff_expected(ff_expected0)
  );

  alu_result_checker #(.WIDTH(4), .CNT_W(16), .CHECK_RESERVED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_result(in_result),
    .chk_valid(chk_valid1), .chk_pass(chk_pass1),
    .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1), .skip_cnt(skip_cnt1),
    .err(err1), .ff_a(ff_a1), .ff_b(ff_b1), .ff_op(ff_op1),
    .ff_result(ff_result1), .ff_expected(ff_expected1)
  );

  typedef struct packed {
    logic        pass;
    logic [31:0] due;
  } exp_t;

  typedef struct {
    int         pass, fail, skip;
    logic       err;
    logic [3:0] fa, fb, fr, fe;
    logic [2:0] fo;
  } model_t;

  exp_t   q0[$];
  exp_t   q1[$];
  model_t m0, m1;
  int     n_total = 0;
  int     n_pass  = 0;
  int     n_fail  = 0;
  logic [31:0] cyc = 0;

  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd1:    return a + b;
      3'd2:    return a - b;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return ~a;
      3'd6:    return ~b;
      default: return 4'd0;
    endcase
  endfunction

  function automatic model_t model_zero();
    model_t m;
    m.pass = 0; m.fail = 0; m.skip = 0; m.err = 1'b0;
    m.fa = '0; m.fb = '0; m.fr = '0; m.fe = '0; m.fo = '0;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mupd(inout model_t m, input int maxv, input logic pass,
                      input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic [3:0] r, input logic [3:0] e);
    if (pass) begin
      if (m.pass < maxv) m.pass++;
    end else begin
      if (m.fail < maxv) m.fail++;
      if (!m.err) begin
        m.err = 1'b1; m.fa = a; m.fb = b; m.fo = op; m.fr = r; m.fe = e;
      end
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (chk_valid0) begin
      if (q0.size() == 0) check("dut0_spurious_pulse", 32'(chk_valid0), 32'd0);
      else begin
        e = q0.pop_front();
        check("dut0_latency", cyc, e.due);
        check("dut0_chk_pass", 32'(chk_pass0), 32'(e.pass));
      end
    end
    if (chk_valid1) begin
      if (q1.size() == 0) check("dut1_spurious_pulse", 32'(chk_valid1), 32'd0);
      else begin
        e = q1.pop_front();
        check("dut1_latency", cyc, e.due);
        check("dut1_chk_pass", 32'(chk_pass1), 32'(e.pass));
      end
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [3:0] r);
    logic [3:0] e;
    logic       p;
    e = ref_alu(a, b, op);
    p = (r == e);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_result = r;
    q1.push_back('{pass: p, due: cyc + 2});
    mupd(m1, 65535, p, a, b, op, r, e);
    if (op == 3'b111) begin
      if (m0.skip < 15) m0.skip++;
    end else begin
      q0.push_back('{pass: p, due: cyc + 2});
      mupd(m0, 15, p, a, b, op, r, e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_pass_cnt0"},    32'(pass_cnt0),    m0.pass);
    check({tag, "_fail_cnt0"},    32'(fail_cnt0),    m0.fail);
    check({tag, "_skip_cnt0"},    32'(skip_cnt0),    m0.skip);
    check({tag, "_err0"},         32'(err0),         32'(m0.err));
    check({tag, "_ff0"},          {13'd0, ff_a0, ff_b0, ff_op0, ff_result0, ff_expected0},
                                  {13'd0, m0.fa, m0.fb, m0.fo, m0.fr, m0.fe});
    check({tag, "_pass_cnt1"},    32'(pass_cnt1),    m1.pass);
    check({tag, "_fail_cnt1"},    32'(fail_cnt1),    m1.fail);
    check({tag, "_skip_cnt1"},    32'(skip_cnt1),    m1.skip);
    check({tag, "_err1"},         32'(err1),         32'(m1.err));
    check({tag, "_ff1"},          {13'd0, ff_a1, ff_b1, ff_op1, ff_result1, ff_expected1},
                                  {13'd0, m1.fa, m1.fb, m1.fo, m1.fr, m1.fe});
  endtask

  task automatic drain(input string tag);
    repeat (3) tick();
    check({tag, "_q0_empty"}, q0.size(), 32'd0);
    check({tag, "_q1_empty"}, q1.size(), 32'd0);
    check_state(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m0 = model_zero();
    m1 = model_zero();
    check("clear_chk_valid0", 32'(chk_valid0), 32'd0);
    check("clear_chk_valid1", 32'(chk_valid1), 32'd0);
  endtask

  logic [3:0] res8 [8];

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_result = '0;
    m0 = model_zero();
    m1 = model_zero();
    res8 = '{4'b0000, 4'b1000, 4'b0010, 4'b0001, 4'b0111, 4'b1010, 4'b1100, 4'b0000};

    // Reset state
    tick(); tick();
    check("reset_chk_valid0", 32'(chk_valid0), 32'd0);
    check("reset_chk_valid1", 32'(chk_valid1), 32'd0);
    check_state("reset");
    rst = 1'b0;
    tick();

    // All eight opcodes back-to-back on A=0101, B=0011
    for (int i = 0; i < 8; i++) drive(4'b0101, 4'b0011, 3'(i), res8[i]);
    drain("ops");
    check("ops_pass_cnt1_is_8", 32'(pass_cnt1), 32'd8);

    // Modulo wrap of add and subtract
    drive(4'b1111, 4'b0001, 3'b001, 4'b0000);
    drive(4'b0000, 4'b0001, 3'b010, 4'b1111);
    drain("wrap");

    // Injected faults: first is captured, second only counted
    do_clear();
    drive(4'b0101, 4'b0011, 3'b001, 4'b0111);
    drive(4'b0101, 4'b0011, 3'b011, 4'b0000);
    drain("fault");
    check("fault_ff_expected1", 32'(ff_expected1), 32'h8);
    check("fault_ff_result1",   32'(ff_result1),   32'h7);

    // Reserved opcode: skipped on dut0, checked against 0 on dut1
    do_clear();
    drive(4'b0101, 4'b0011, 3'b111, 4'b1010);
    drain("rsvd");

    // Counter saturation: dut0 holds at 15, dut1 reaches 20
    do_clear();
    for (int i = 0; i < 20; i++)
      drive(4'(i), 4'b0011, 3'b001, ref_alu(4'(i), 4'b0011, 3'b001));
    drain("sat");

    // clear at the edge where the first of two in-flight faults resolves
    in_valid = 1'b1; in_a = 4'b0101; in_b = 4'b0011; in_op = 3'b001; in_result = 4'b0111;
    tick();
    in_op = 3'b011; in_result = 4'b0000; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    m0 = model_zero();
    m1 = model_zero();
    check("inflight_chk_valid0", 32'(chk_valid0), 32'd0);
    check("inflight_chk_valid1", 32'(chk_valid1), 32'd0);
    drain("inflight");

    // Asynchronous reset mid-stream, while a pulse is showing
    drive(4'b0011, 4'b0001, 3'b001, 4'b0100);
    drive(4'b0011, 4'b0001, 3'b100, 4'b0011);
    #2;
    rst = 1'b1;
    #1;
    q0.delete();
    q1.delete();
    m0 = model_zero();
    m1 = model_zero();
    check("async_rst_chk_valid0", 32'(chk_valid0), 32'd0);
    check("async_rst_chk_valid1", 32'(chk_valid1), 32'd0);
    check_state("async_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_pulse0", 32'(chk_valid0), 32'd0);
      check("post_rst_no_pulse1", 32'(chk_valid1), 32'd0);
    end
    check_state("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
